mips_run_controller: RTL

- Execution sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Gates the pipeline's global advance enable and supports free run, single step, pause and clear.
- Detects the HALT instruction in the ID stage, drains the instructions ahead of it, then freezes the pipeline and reports Halted.
- Sits between the command source (debug unit / UART front end) and the MIPS top level.

---
 rtl/mips_run_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips_run_controller.sv
// Run/step/halt sequencer for the 5-stage MIPS pipeline: gates the global advance enable,
// detects HALT in ID, drains the instructions ahead of it and freezes in HALTED.
module mips_run_controller #(
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic             CmdValid,
    input  logic [1:0]       CmdOp,
    output logic             CmdReady,
    input  logic [31:0]      Instruction_ID,
    output logic             PipeEnable,
    output logic             FetchHold,
    output logic             PipeClear,
    output logic             StepDone,
    output logic             Halted,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] CycleCount
);

    localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] OpStop  = 2'b00;
    localparam logic [1:0] OpRun   = 2'b01;
    localparam logic [1:0] OpStep  = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StDrain  = 3'd3,
        StHalted = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DrainW-1:0]  drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_done_q, step_done_d;
    logic               clear_q, clear_d;
    logic               cmd_fire;
    logic               halt_hit;
    logic               cnt_clear;

    always_comb begin
        CmdReady   = (state_q == StIdle) || (state_q == StRun) || (state_q == StHalted);
        PipeEnable = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);
        halt_hit   = ((state_q == StRun) || (state_q == StStep)) &&
                     (Instruction_ID == HALT_INSTR);
        FetchHold  = (state_q == StDrain) || halt_hit;
        Halted     = (state_q == StHalted);
        State      = state_q;
        PipeClear  = clear_q;
        StepDone   = step_done_q;
        CycleCount = cnt_q;
        cmd_fire   = CmdValid && CmdReady;
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        step_done_d = 1'b0;
        clear_d     = 1'b0;
        cnt_clear   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    case (CmdOp)
                        OpRun:   state_d = StRun;
                        OpStep:  state_d = StStep;
                        OpClear: begin
                            clear_d   = 1'b1;
                            cnt_clear = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StRun, StStep: begin
                if (halt_hit) begin
                    // HALT leaves ID this edge; it still has EX/MEM/WB ahead of it.
                    if (DRAIN_CYCLES == 0) begin
                        state_d = StHalted;
                    end else begin
                        state_d = StDrain;
                        drain_d = DrainW'(DRAIN_CYCLES);
                    end
                end else if (state_q == StStep) begin
                    state_d     = StIdle;
                    step_done_d = 1'b1;
                end else if (cmd_fire && (CmdOp == OpStop)) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                drain_d = drain_q - DrainW'(1);
                if (drain_q <= DrainW'(1)) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (cmd_fire && (CmdOp == OpClear)) begin
                    state_d   = StIdle;
                    clear_d   = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (PipeEnable && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q     <= StIdle;
            drain_q     <= '0;
            cnt_q       <= '0;
            step_done_q <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cnt_q       <= cnt_d;
            step_done_q <= step_done_d;
            clear_q     <= clear_d;
        end
    end

endmodule
